// File: rtl/cache_fill_pkg.sv
// cache_fill_pkg: shared types and helpers for the cache miss fill controller.
// Holds the FSM state enum, block-offset sizing and the block-base address mask.
package cache_fill_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } fill_state_t;

    localparam int unsigned DEFAULT_BLOCK_WORDS = 8;

    // Byte-offset bits inside one block of 16-bit words: log2(words) + 1.
    function automatic int unsigned offset_bits(input int unsigned block_words);
        return $clog2(block_words) + 1;
    endfunction

    localparam int unsigned OFFSET_BITS = offset_bits(DEFAULT_BLOCK_WORDS);

    // Clears the in-block byte offset so the fill always starts at word 0.
    function automatic logic [31:0] block_base(input logic [31:0] addr,
                                               input int unsigned off_bits);
        return addr & ~((32'd1 << off_bits) - 32'd1);
    endfunction

endpackage

// File: rtl/fill_counter.sv
// fill_counter: clear-and-increment counter with a terminal-value flag.
// Used once for issued requests and once for received words of a fill.
module fill_counter #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned TERMINAL = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             incr,
    output logic [WIDTH-1:0] count,
    output logic             at_terminal
);

    assign at_terminal = (count == WIDTH'(TERMINAL));

    // Count register: clear wins over increment so a new fill always starts at 0.
    // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (incr) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/cache_fill_fsm.sv
// cache_fill_fsm: miss-handling controller. Latches the block base on a miss,
// issues one memory read per cycle for every word of the block, steers the
// returning words into the data array and writes the tag after the last word.
// Optional build macro CACHE_FILL_PERF_CNT_EN adds a saturating fill_count output.
module cache_fill_fsm
    import cache_fill_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH  = 16,
    parameter int unsigned BLOCK_WORDS = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           miss_detected,
    input  logic [ADDR_WIDTH-1:0]          miss_address,
    input  logic [15:0]                    mem_data_in,
    input  logic                           mem_data_valid,
    output logic                           fsm_busy,
    output logic                           mem_enable,
    output logic [ADDR_WIDTH-1:0]          memory_address,
    output logic                           write_data_array,
    output logic [$clog2(BLOCK_WORDS)-1:0] cache_word_sel,
    output logic [15:0]                    cache_data_out,
    output logic                           write_tag_array
`ifdef CACHE_FILL_PERF_CNT_EN
   ,output logic [15:0]                    fill_count
`endif
);

    localparam int unsigned OFF_W = offset_bits(BLOCK_WORDS);
    localparam int unsigned SEL_W = OFF_W - 1;

    fill_state_t            state;
    fill_state_t            state_next;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [OFF_W-1:0]       issue_cnt;
    logic [OFF_W-1:0]       recv_cnt;
    logic                   issue_last;
    logic                   recv_last;
    logic                   fill_start;
    logic                   issue_fire;
    logic                   recv_accept;

    // Responses only count while a fill is active; stale ones after reset are dropped.
    assign fill_start  = (state == IDLE) && miss_detected;
    assign issue_fire  = (state == ISSUE);
    assign recv_accept = (state != IDLE) && mem_data_valid;

    fill_counter #(
        .WIDTH    (OFF_W),
        .TERMINAL (BLOCK_WORDS - 1)
    ) u_issue_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (fill_start),
        .incr        (issue_fire),
        .count       (issue_cnt),
        .at_terminal (issue_last)
    );

    fill_counter #(
        .WIDTH    (OFF_W),
        .TERMINAL (BLOCK_WORDS - 1)
    ) u_recv_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (fill_start),
        .incr        (recv_accept),
        .count       (recv_cnt),
        .at_terminal (recv_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: issue all words, then wait for the last response.
    // NOTE: state_next takes a default first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (miss_detected) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (issue_last) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // The MSB guard only matters if the count ever overshoots; it then forces a clean exit.
                if ((recv_accept && recv_last) || recv_cnt[OFF_W-1]) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request-side outputs decoded from the current state.
    always_comb begin
        mem_enable     = issue_fire;
        memory_address = '0;
        if (issue_fire) begin
            memory_address = base_q + ADDR_WIDTH'({issue_cnt, 1'b0});
        end
        fsm_busy = (state != IDLE) | write_tag_array;
    end

    // Block base is captured once per fill; later misses are ignored until IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
        end else if (fill_start) begin
            base_q <= ADDR_WIDTH'(block_base(32'(miss_address), OFF_W));
        end
    end

    // Write-side registers: each accepted response becomes a data-array write next cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cache_data_out   <= '0;
            cache_word_sel   <= '0;
            write_data_array <= 1'b0;
            write_tag_array  <= 1'b0;
        end else begin
            write_data_array <= recv_accept;
            write_tag_array  <= recv_accept && recv_last;
            if (recv_accept) begin
                cache_data_out <= mem_data_in;
                cache_word_sel <= recv_cnt[SEL_W-1:0];
            end
        end
    end

`ifdef CACHE_FILL_PERF_CNT_EN
    // Completed-fill counter, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_count <= '0;
        end else if (write_tag_array && (fill_count != 16'hFFFF)) begin
            fill_count <= fill_count + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cache_fill_fsm.sv
// tb_cache_fill_fsm: self-checking bench for cache_fill_fsm (ADDR_WIDTH 16, 8 words).
// A latency-configurable memory returns word value = byte address; a cycle-level
// reference model built from the fill rules predicts every output each cycle.
module tb_cache_fill_fsm;

    localparam int AW = 16;
    localparam int BW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          miss_detected = 1'b0;
    logic [AW-1:0] miss_address = '0;
    logic [15:0]   mem_data_in = '0;
    logic          mem_data_valid = 1'b0;
    logic          fsm_busy;
    logic          mem_enable;
    logic [AW-1:0] memory_address;
    logic          write_data_array;
    logic [2:0]    cache_word_sel;
    logic [15:0]   cache_data_out;
    logic          write_tag_array;
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [15:0]   fill_count;
`endif

    always #5 clk = ~clk;

    cache_fill_fsm #(
        .ADDR_WIDTH  (AW),
        .BLOCK_WORDS (BW)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .miss_detected    (miss_detected),
        .miss_address     (miss_address),
        .mem_data_in      (mem_data_in),
        .mem_data_valid   (mem_data_valid),
        .fsm_busy         (fsm_busy),
        .mem_enable       (mem_enable),
        .memory_address   (memory_address),
        .write_data_array (write_data_array),
        .cache_word_sel   (cache_word_sel),
        .cache_data_out   (cache_data_out),
        .write_tag_array  (write_tag_array)
`ifdef CACHE_FILL_PERF_CNT_EN
       ,.fill_count       (fill_count)
`endif
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Memory: in-order responses, each due a fixed number of cycles after its request.
    typedef struct { int due; logic [15:0] data; } resp_t;
    resp_t mem_q[$];
    int    mem_lat = 4;

    // Reference model of the fill, in terms of words issued / received.
    bit          m_active;
    logic [15:0] m_base;
    int          m_issued;
    int          m_recv;
    bit          m_wr;
    int          m_sel;
    logic [15:0] m_data;
    bit          m_tag;
    int          m_fills;

    // Observation log for the current scenario.
    int          req_cycles[$];
    logic [15:0] req_addrs[$];
    int          wr_sels[$];
    logic [15:0] wr_data[$];
    int          tag_cycles[$];

    int cyc = 0;

    task automatic model_reset();
        m_active = 0; m_base = '0; m_issued = 0; m_recv = 0;
        m_wr = 0; m_sel = 0; m_data = '0; m_tag = 0; m_fills = 0;
    endtask

    task automatic clear_obs();
        req_cycles.delete(); req_addrs.delete();
        wr_sels.delete(); wr_data.delete(); tag_cycles.delete();
    endtask

    function automatic logic [38:0] dut_outs();
        return {mem_enable, memory_address, write_data_array, cache_word_sel,
                cache_data_out, write_tag_array, fsm_busy};
    endfunction

    function automatic logic [38:0] model_outs();
        bit          en = m_active && (m_issued < BW);
        logic [15:0] a  = en ? m_base + 16'(2 * m_issued) : 16'h0;
        return {en, a, m_wr, 3'(m_sel), m_data, m_tag, m_active || m_tag};
    endfunction

    // One clock cycle: drive memory response, compare at negedge, log, advance model.
    task automatic step();
        resp_t       r;
        bit          en;
        logic [15:0] mask;
        mem_data_valid = 1'b0;
        mem_data_in    = 16'($urandom);
        if (mem_q.size() > 0 && mem_q[0].due == cyc) begin
            r = mem_q.pop_front();
            mem_data_valid = 1'b1;
            mem_data_in    = r.data;
        end
        @(negedge clk);
        check($sformatf("cyc%0d_outputs", cyc), dut_outs(), model_outs());
        if (mem_enable) begin
            req_cycles.push_back(cyc);
            req_addrs.push_back(memory_address);
            mem_q.push_back('{cyc + mem_lat, memory_address});
        end
        if (write_data_array) begin
            wr_sels.push_back(int'(cache_word_sel));
            wr_data.push_back(cache_data_out);
        end
        if (write_tag_array) tag_cycles.push_back(cyc);
        if (!rst_n) begin
            model_reset();
        end else begin
            en   = m_active && (m_issued < BW);
            m_wr = 0;
            m_tag = 0;
            if (m_active) begin
                if (en) m_issued++;
                if (mem_data_valid) begin
                    m_wr   = 1;
                    m_sel  = m_recv;
                    m_data = mem_data_in;
                    m_tag  = (m_recv == BW - 1);
                    m_recv++;
                    if (m_recv == BW) begin
                        m_active = 0;
                        m_fills++;
                    end
                end
            end else if (miss_detected) begin
                mask     = 16'(2 * BW - 1);
                m_active = 1;
                m_base   = miss_address & ~mask;
                m_issued = 0;
                m_recv   = 0;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // noise: 0 none, 1 toggle miss to 0x8000, 2 random miss/address; only during ISSUE.
    task automatic run_fill(input logic [15:0] addr, input int lat, input int noise, output int t0);
        mem_lat = lat;
        clear_obs();
        miss_detected = 1'b1;
        miss_address  = addr;
        t0 = cyc;
        step();
        miss_detected = 1'b0;
        for (int i = 0; i < 60 && tag_cycles.size() == 0; i++) begin
            miss_detected = 1'b0;
            if (cyc < t0 + BW) begin
                if (noise == 1) begin
                    miss_detected = cyc[0];
                    miss_address  = 16'h8000;
                end else if (noise == 2) begin
                    miss_detected = 1'($urandom_range(0, 1));
                    miss_address  = 16'($urandom);
                end
            end
            step();
        end
        miss_detected = 1'b0;
    endtask

    // Whole-fill checks: request stream, written words in order, single tag write.
    task automatic check_fill(input string nm, input int t0, input logic [15:0] base,
                              input int tag_off);
        int bad_req = 0;
        int bad_wr  = 0;
        int first   = -1;
        int last    = -1;
        int toff    = -1;
        if (req_cycles.size() > 0) begin
            first = req_cycles[0] - t0;
            last  = req_cycles[req_cycles.size() - 1] - t0;
        end
        if (tag_cycles.size() > 0) toff = tag_cycles[0] - t0;
        foreach (req_addrs[i]) if (req_addrs[i] !== base + 16'(2 * i)) bad_req++;
        foreach (wr_data[i])
            if (wr_data[i] !== base + 16'(2 * i) || wr_sels[i] != i) bad_wr++;
        check({nm, "_req_count"}, req_addrs.size(), BW);
        check({nm, "_first_req_cycle"}, first, 1);
        check({nm, "_last_req_cycle"}, last, BW);
        check({nm, "_req_addr_errors"}, bad_req, 0);
        check({nm, "_write_count"}, wr_data.size(), BW);
        check({nm, "_write_errors"}, bad_wr, 0);
        check({nm, "_tag_count"}, tag_cycles.size(), 1);
        check({nm, "_tag_cycle"}, toff, tag_off);
    endtask

    typedef struct {
        logic [15:0] addr;
        int          lat;
        int          noise;
        logic [15:0] exp_base;
        int          exp_tag_off;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          t0;
        int          bad;
        logic [15:0] a;
        int          lat;

        vecs[0] = '{16'h1236, 4, 0, 16'h1230, 13};
        vecs[1] = '{16'h1236, 4, 1, 16'h1230, 13};
        vecs[2] = '{16'h0ABC, 1, 0, 16'h0AB0, 10};
        vecs[3] = '{16'hFFFF, 7, 0, 16'hFFF0, 16};

        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("por_outputs", dut_outs(), 39'h0);
`ifdef CACHE_FILL_PERF_CNT_EN
        check("por_fill_count", fill_count, 16'h0);
`endif
        rst_n = 1'b1;
        repeat (2) step();

        // Table-driven fills.
        for (int i = 0; i < 4; i++) begin
            run_fill(vecs[i].addr, vecs[i].lat, vecs[i].noise, t0);
            check_fill($sformatf("vec%0d", i), t0, vecs[i].exp_base, vecs[i].exp_tag_off);
            repeat (2) step();
`ifdef CACHE_FILL_PERF_CNT_EN
            if (i == 2) check("fill_count_after_3", fill_count, 16'd3);
`endif
        end

        // Reset in cycle 7 of a fill: outputs drop at once, leftover responses are ignored.
        mem_lat = 4;
        clear_obs();
        miss_detected = 1'b1;
        miss_address  = 16'h2468;
        step();
        miss_detected = 1'b0;
        repeat (6) step();
        rst_n = 1'b0;
        #1;
        check("midfill_reset_outputs", dut_outs(), 39'h0);
        model_reset();
        clear_obs();
        repeat (2) step();
        rst_n = 1'b1;
`ifdef CACHE_FILL_PERF_CNT_EN
        check("fill_count_after_reset", fill_count, 16'h0);
`endif
        repeat (12) step();
        check("post_reset_writes", wr_data.size(), 0);
        check("post_reset_tags", tag_cycles.size(), 0);
        check("post_reset_reqs", req_addrs.size(), 0);

        // Back-to-back: miss held high across completion starts the next fill at once.
        mem_lat = 3;
        clear_obs();
        miss_detected = 1'b1;
        miss_address  = 16'h4442;
        step();
        miss_address  = 16'h9A5E;
        for (int i = 0; i < 60 && tag_cycles.size() == 0; i++) step();
        miss_detected = 1'b0;
        for (int i = 0; i < 60 && tag_cycles.size() < 2; i++) step();
        check("b2b_tag_count", tag_cycles.size(), 2);
        check("b2b_req_count", req_addrs.size(), 2 * BW);
        check("b2b_write_count", wr_data.size(), 2 * BW);
        if (tag_cycles.size() > 0 && req_cycles.size() > BW)
            check("b2b_second_start", req_cycles[BW], tag_cycles[0] + 1);
        else
            check("b2b_second_start", req_cycles.size(), BW + 1);
        bad = 0;
        foreach (wr_data[i]) begin
            a = (i < BW) ? 16'h4440 : 16'h9A50;
            if (wr_data[i] !== a + 16'(2 * (i % BW)) || wr_sels[i] != i % BW) bad++;
        end
        check("b2b_word_errors", bad, 0);
        repeat (2) step();

        // Randomized fills with random latency, address and miss noise.
        for (int n = 0; n < 20; n++) begin
            a   = 16'($urandom);
            lat = $urandom_range(1, 7);
            run_fill(a, lat, int'($urandom_range(0, 2)), t0);
            check_fill($sformatf("rnd%0d", n), t0, a & 16'hFFF0, BW + lat + 1);
            repeat ($urandom_range(1, 3)) step();
        end
`ifdef CACHE_FILL_PERF_CNT_EN
        check("fill_count_final", fill_count, 16'(m_fills));
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cache_fill_fsm.md
# cache_fill_fsm

Miss-handling controller between the cache arrays and the multi-cycle main memory. On a cache miss it latches the block address, issues one pipelined 16-bit read per cycle for every word of the block, and counts returning `data_valid` pulses. It steers each returned word into the cache data array and writes the tag once the last word lands. It is the sole master of the memory read port during a fill.

## Interface
- `ADDR_WIDTH`, 16: byte-address width; matches memory.
- `BLOCK_WORDS`, 8: 16-bit words per cache block; power of two, 2..16.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `miss_detected` in 1: cache reports a miss; sampled only in IDLE.
- `miss_address` in ADDR_WIDTH: byte address of the missing access.
- `mem_data_in` in 16: memory read data.
- `mem_data_valid` in 1: memory read data valid.
- `fsm_busy` out 1: fill in progress; stalls pipeline.
- `mem_enable` out 1: memory read request this cycle; write strobe to memory is tied 0 by the parent.
- `memory_address` out ADDR_WIDTH: memory request address.
- `write_data_array` out 1: write `cache_data_out` into word `cache_word_sel` of the block.
- `cache_word_sel` out log2(BLOCK_WORDS): word offset being written.
- `cache_data_out` out 16: registered copy of `mem_data_in`.
- `write_tag_array` out 1: single-cycle tag/valid write for the filled block.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE: on `miss_detected` = 1, latch the block base (`miss_address` with the low log2(BLOCK_WORDS)+1 bits cleared), clear `issue_cnt` and `recv_cnt`, and go to ISSUE.
- ISSUE: `mem_enable` = 1, `memory_address` = base + 2·`issue_cnt`. Increment `issue_cnt`. After issuing word BLOCK_WORDS−1, go to DRAIN.
- DRAIN: `mem_enable` = 0. Wait for outstanding data.
- In ISSUE and DRAIN, each `mem_data_valid` = 1:
  - registers `mem_data_in` into `cache_data_out`;
  - pulses `write_data_array` on the next cycle with `cache_word_sel` = `recv_cnt`;
  - then increments `recv_cnt`.
- When the word with `recv_cnt` = BLOCK_WORDS−1 is written, `write_tag_array` pulses in the same cycle, and the state returns to IDLE.
- `mem_data_valid` in IDLE is ignored. This covers stale responses after a reset mid-fill.
- `miss_detected` in ISSUE or DRAIN is ignored, and `miss_address` is not re-sampled.
- `miss_detected` still high in the cycle after return to IDLE starts a new fill. The cache must drop `miss_detected` once the tag write makes it hit.
- Counters are log2(BLOCK_WORDS)+1 bits wide. They never wrap during a fill and are cleared on fill start.
- `fsm_busy` = (state != IDLE) | `write_tag_array`.

## Timing
- Reset values: all outputs 0, state IDLE, counters 0, latched base 0.
- Async reset at any point aborts the fill immediately. The partially written block stays tag-invalid because `write_tag_array` never fired.
- With memory latency L = 4 and the miss accepted at cycle 0:
  - requests go out in cycles 1..BLOCK_WORDS;
  - `mem_data_valid` arrives in cycles 5..BLOCK_WORDS+4;
  - `write_data_array` fires in cycles 6..BLOCK_WORDS+5;
  - `write_tag_array` fires in cycle BLOCK_WORDS+5, which is cycle 13 for 8 words;
  - `fsm_busy` is high in cycles 1..BLOCK_WORDS+5.
- Correctness depends only on `mem_data_valid` count and order, not on L. The memory returns data in request order.

## Configuration
- `CACHE_FILL_PERF_CNT_EN`
  - Defined: adds output `fill_count`, 16 bits, reset 0. It increments on each `write_tag_array` and saturates at 0xFFFF.
  - Undefined: the port and the counter are absent. All other behaviour is identical.

## Structure
- Package `cache_fill_pkg` holds:
  - state enum `fill_state_t` (IDLE, ISSUE, DRAIN);
  - `OFFSET_BITS` = log2(BLOCK_WORDS) + 1;
  - a helper `block_base` function for address masking.
- Sub-module `fill_counter` is a clear-and-increment counter with terminal flag. It is instantiated twice, for issue and receive.

## Test plan
- Miss at 0x1236, BLOCK_WORDS = 8, memory preloaded with word value = address: requests go to 0x1230..0x123E in cycles 1..8. Eight data writes follow with sel 0..7 and data 0x1230..0x123E, and `write_tag_array` fires at cycle 13.
- `miss_detected` toggles to 0x8000 during ISSUE: the fill still targets the original block, and no second fill starts until IDLE.
- `rst_n` low at cycle 7: all outputs go to 0 immediately and `write_tag_array` never fires. After release, leftover `mem_data_valid` pulses produce no writes.
- Back-to-back misses, with `miss_detected` held high across completion: the second fill requests start the cycle after IDLE is re-entered, with no lost or duplicated words.
- Memory model with latency 1 and then 7: same word order and values, and `write_tag_array` fires exactly once per fill.
- With `CACHE_FILL_PERF_CNT_EN`: after 3 fills, `fill_count` = 3. After reset it reads 0.
